// File: rtl/xalu_ise_pkg.sv
// Shared constants for the xalu_ise issue controller: opcode selectors,
// FSM state encoding and requester port indices.
package xalu_ise_pkg;

    localparam logic [1:0] CUSTOM_0 = 2'd0;
    localparam logic [1:0] CUSTOM_1 = 2'd1;
    localparam logic [1:0] CUSTOM_2 = 2'd2;
    localparam logic [1:0] CUSTOM_3 = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/xalu_ise_rr_arb.sv
// Two-way arbiter: round-robin on the last winner, or port 0 fixed priority
// with a saturating starvation counter that forces a port 1 grant.
module xalu_ise_rr_arb
    import xalu_ise_pkg::*;
#(
    parameter logic       PRIO_FIX   = 1'b0,
    parameter logic [3:0] STARVE_MAX = 4'd8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic elig0,
    input  logic elig1,
    input  logic val1,
    output logic grant0,
    output logic grant1
);

    logic       last;
    logic [3:0] starve;

    always_comb begin
        // NOTE: defaults first so every path assigns both grants; no latch.
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (PRIO_FIX == 1'b0) begin
            if (elig0 && elig1) begin
                grant0 = (last == PORT1);
                grant1 = (last == PORT0);
            end else begin
                grant0 = elig0;
                grant1 = elig1;
            end
        end else begin
            grant1 = elig1 && (!elig0 || starve == STARVE_MAX);
            grant0 = elig0 && !grant1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all state; reset is sampled on the edge.
        if (!rst_n) begin
            last   <= PORT0;
            starve <= 4'd0;
        end else begin
            if (grant0 || grant1)
                last <= grant1 ? PORT1 : PORT0;
            if (grant1)
                starve <= 4'd0;
            else if (val1 && starve != STARVE_MAX)
                starve <= starve + 4'd1;
        end
    end

endmodule

// File: rtl/xalu_ise_arb.sv
// Two-port issue controller for a shared combinational xalu_ise: arbitrates,
// registers the winning op into a one-cycle issue stage, buffers each result.
module xalu_ise_arb
    import xalu_ise_pkg::*;
#(
    parameter logic       PRIO_FIX   = 1'b0,
    parameter logic [3:0] STARVE_MAX = 4'd8
) (
    input  logic        ise_clk,
    input  logic        ise_rst,
    input  logic        req0_val,
    output logic        req0_rdy,
    input  logic [4:0]  req0_fn,
    input  logic [6:0]  req0_imm,
    input  logic [31:0] req0_in1,
    input  logic [31:0] req0_in2,
    input  logic        req1_val,
    output logic        req1_rdy,
    input  logic [4:0]  req1_fn,
    input  logic [6:0]  req1_imm,
    input  logic [31:0] req1_in1,
    input  logic [31:0] req1_in2,
    output logic        rsp0_val,
    input  logic        rsp0_rdy,
    output logic [31:0] rsp0_out,
    output logic        rsp0_err,
    output logic        rsp1_val,
    input  logic        rsp1_rdy,
    output logic [31:0] rsp1_out,
    output logic        rsp1_err,
    output logic        ise_val,
    output logic [4:0]  ise_fn,
    output logic [6:0]  ise_imm,
    output logic [31:0] ise_in1,
    output logic [31:0] ise_in2,
    input  logic        ise_oval,
    input  logic [31:0] ise_out
);

    state_t      state;
    logic        owner;
    logic        grant0, grant1;
    logic        elig0, elig1;
    logic        cap0, cap1;
    logic [31:0] result;

    // A port may not re-issue while its op is in flight or its buffer is still held.
    assign elig0 = req0_val && !(rsp0_val && !rsp0_rdy) && !(state == EXEC && owner == PORT0);
    assign elig1 = req1_val && !(rsp1_val && !rsp1_rdy) && !(state == EXEC && owner == PORT1);

    assign req0_rdy = grant0;
    assign req1_rdy = grant1;

    assign cap0   = (state == EXEC) && (owner == PORT0);
    assign cap1   = (state == EXEC) && (owner == PORT1);
    assign result = ise_oval ? ise_out : 32'd0;

    xalu_ise_rr_arb #(
        .PRIO_FIX   (PRIO_FIX),
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk    (ise_clk),
        .rst_n  (ise_rst),
        .elig0  (elig0),
        .elig1  (elig1),
        .val1   (req1_val),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    always_ff @(posedge ise_clk) begin
        if (!ise_rst) begin
            state   <= IDLE;
            owner   <= PORT0;
            ise_val <= 1'b0;
            ise_fn  <= 5'd0;
            ise_imm <= 7'd0;
            ise_in1 <= 32'd0;
            ise_in2 <= 32'd0;
        end else if (grant0 || grant1) begin
            state   <= EXEC;
            ise_val <= 1'b1;
            owner   <= grant1 ? PORT1 : PORT0;
            ise_fn  <= grant1 ? req1_fn  : req0_fn;
            ise_imm <= grant1 ? req1_imm : req0_imm;
            ise_in1 <= grant1 ? req1_in1 : req0_in1;
            ise_in2 <= grant1 ? req1_in2 : req0_in2;
        end else begin
            state   <= IDLE;
            ise_val <= 1'b0;
        end
    end

    always_ff @(posedge ise_clk) begin
        if (!ise_rst) begin
            rsp0_val <= 1'b0;
            rsp0_out <= 32'd0;
            rsp0_err <= 1'b0;
        end else if (cap0) begin
            rsp0_val <= 1'b1;
            rsp0_out <= result;
            rsp0_err <= !ise_oval;
        end else if (rsp0_val && rsp0_rdy) begin
            rsp0_val <= 1'b0;
        end
    end

    always_ff @(posedge ise_clk) begin
        if (!ise_rst) begin
            rsp1_val <= 1'b0;
            rsp1_out <= 32'd0;
            rsp1_err <= 1'b0;
        end else if (cap1) begin
            rsp1_val <= 1'b1;
            rsp1_out <= result;
            rsp1_err <= !ise_oval;
        end else if (rsp1_val && rsp1_rdy) begin
            rsp1_val <= 1'b0;
        end
    end

endmodule

// File: tb/tb_xalu_ise_arb.sv
// Bench for xalu_ise_arb: a round-robin and a fixed-priority instance share one
// transaction-level model that predicts grants, issue contents and responses.
module tb_xalu_ise_arb;
    import xalu_ise_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        r_val [2][2];
    logic [4:0]  r_fn  [2][2];
    logic [6:0]  r_imm [2][2];
    logic [31:0] r_in1 [2][2];
    logic [31:0] r_in2 [2][2];
    logic        q_rdy [2][2];
    logic        s_val [2][2];
    logic        s_rdy [2][2];
    logic [31:0] s_out [2][2];
    logic        s_err [2][2];
    logic        i_val [2];
    logic [4:0]  i_fn  [2];
    logic [6:0]  i_imm [2];
    logic [31:0] i_in1 [2];
    logic [31:0] i_in2 [2];
    logic        i_oval[2];
    logic [31:0] i_out [2];

    int n_tests = 0;
    int n_fail  = 0;

    // Stand-in ISE: CUSTOM_3 is unclaimed and returns junk that must not leak out.
    function automatic logic [32:0] ise_ref(input logic [4:0] fn, input logic [6:0] imm,
                                            input logic [31:0] a, input logic [31:0] b);
        case (fn[1:0])
            CUSTOM_0: return {1'b1, a ^ {b[15:0], b[31:16]}};
            CUSTOM_1: return {1'b1, a + b + {25'd0, imm}};
            CUSTOM_2: return {1'b1, a - (b >> imm[4:0])};
            default:  return {1'b0, 32'hDEAD_BEEF};
        endcase
    endfunction

    assign {i_oval[0], i_out[0]} = ise_ref(i_fn[0], i_imm[0], i_in1[0], i_in2[0]);
    assign {i_oval[1], i_out[1]} = ise_ref(i_fn[1], i_imm[1], i_in1[1], i_in2[1]);

    xalu_ise_arb #(.PRIO_FIX(1'b0), .STARVE_MAX(4'd8)) dut_rr (
        .ise_clk(clk), .ise_rst(rst),
        .req0_val(r_val[0][0]), .req0_rdy(q_rdy[0][0]), .req0_fn(r_fn[0][0]),
        .req0_imm(r_imm[0][0]), .req0_in1(r_in1[0][0]), .req0_in2(r_in2[0][0]),
        .req1_val(r_val[0][1]), .req1_rdy(q_rdy[0][1]), .req1_fn(r_fn[0][1]),
        .req1_imm(r_imm[0][1]), .req1_in1(r_in1[0][1]), .req1_in2(r_in2[0][1]),
        .rsp0_val(s_val[0][0]), .rsp0_rdy(s_rdy[0][0]), .rsp0_out(s_out[0][0]), .rsp0_err(s_err[0][0]),
        .rsp1_val(s_val[0][1]), .rsp1_rdy(s_rdy[0][1]), .rsp1_out(s_out[0][1]), .rsp1_err(s_err[0][1]),
        .ise_val(i_val[0]), .ise_fn(i_fn[0]), .ise_imm(i_imm[0]), .ise_in1(i_in1[0]),
        .ise_in2(i_in2[0]), .ise_oval(i_oval[0]), .ise_out(i_out[0])
    );

    xalu_ise_arb #(.PRIO_FIX(1'b1), .STARVE_MAX(4'd3)) dut_fix (
        .ise_clk(clk), .ise_rst(rst),
        .req0_val(r_val[1][0]), .req0_rdy(q_rdy[1][0]), .req0_fn(r_fn[1][0]),
        .req0_imm(r_imm[1][0]), .req0_in1(r_in1[1][0]), .req0_in2(r_in2[1][0]),
        .req1_val(r_val[1][1]), .req1_rdy(q_rdy[1][1]), .req1_fn(r_fn[1][1]),
        .req1_imm(r_imm[1][1]), .req1_in1(r_in1[1][1]), .req1_in2(r_in2[1][1]),
        .rsp0_val(s_val[1][0]), .rsp0_rdy(s_rdy[1][0]), .rsp0_out(s_out[1][0]), .rsp0_err(s_err[1][0]),
        .rsp1_val(s_val[1][1]), .rsp1_rdy(s_rdy[1][1]), .rsp1_out(s_out[1][1]), .rsp1_err(s_err[1][1]),
        .ise_val(i_val[1]), .ise_fn(i_fn[1]), .ise_imm(i_imm[1]), .ise_in1(i_in1[1]),
        .ise_in2(i_in2[1]), .ise_oval(i_oval[1]), .ise_out(i_out[1])
    );

    // Reference model: one pending op per instance, one buffered response per port.
    logic        m_iv   [2];
    logic        m_own  [2];
    logic [75:0] m_op   [2];
    logic        m_rv   [2][2];
    logic [31:0] m_ro   [2][2];
    logic        m_re   [2][2];
    int          m_last [2];
    int          m_cnt  [2];
    int          last_win [2];
    int          smax [2] = '{8, 3};

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_iv[d] = 1'b0; m_own[d] = 1'b0; m_op[d] = '0;
            m_last[d] = 0; m_cnt[d] = 0; last_win[d] = -1;
            for (int p = 0; p < 2; p++) begin
                m_rv[d][p] = 1'b0; m_ro[d][p] = '0; m_re[d][p] = 1'b0;
            end
        end
    endtask

    task automatic idle_inputs();
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) begin
                r_val[d][p] = 1'b0; r_fn[d][p] = '0; r_imm[d][p] = '0;
                r_in1[d][p] = '0; r_in2[d][p] = '0; s_rdy[d][p] = 1'b1;
            end
    endtask

    // One clock cycle: compare both instances against the model, then advance it.
    task automatic tick();
        logic e [2][2];
        int   win [2];
        logic [32:0] res;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++)
                e[d][p] = r_val[d][p] && !(m_rv[d][p] && !s_rdy[d][p]) && !(m_iv[d] && m_own[d] == p[0]);
            if (e[d][0] && e[d][1])
                win[d] = (d == 0) ? 1 - m_last[d] : ((m_cnt[d] == smax[d]) ? 1 : 0);
            else if (e[d][0]) win[d] = 0;
            else if (e[d][1]) win[d] = 1;
            else win[d] = -1;
            for (int p = 0; p < 2; p++) begin
                n_tests++;
                if (q_rdy[d][p] !== (win[d] == p)) begin
                    n_fail++;
                    $display("FAIL rdy d%0d p%0d: got %b want %b @%0t", d, p, q_rdy[d][p], win[d] == p, $time);
                end
                n_tests++;
                if ({s_val[d][p], s_err[d][p], s_out[d][p]} !== {m_rv[d][p], m_re[d][p], m_ro[d][p]}) begin
                    n_fail++;
                    $display("FAIL rsp d%0d p%0d: got v=%b e=%b o=%h want v=%b e=%b o=%h @%0t", d, p,
                             s_val[d][p], s_err[d][p], s_out[d][p], m_rv[d][p], m_re[d][p], m_ro[d][p], $time);
                end
            end
            n_tests++;
            if ({i_val[d], i_fn[d], i_imm[d], i_in1[d], i_in2[d]} !== {m_iv[d], m_op[d]}) begin
                n_fail++;
                $display("FAIL issue d%0d: got v=%b op=%h want v=%b op=%h @%0t", d,
                         i_val[d], {i_fn[d], i_imm[d], i_in1[d], i_in2[d]}, m_iv[d], m_op[d], $time);
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                if (m_rv[d][p] && s_rdy[d][p]) m_rv[d][p] = 1'b0;
                if (m_iv[d] && m_own[d] == p[0]) begin
                    res = ise_ref(m_op[d][75:71], m_op[d][70:64], m_op[d][63:32], m_op[d][31:0]);
                    m_rv[d][p] = 1'b1;
                    m_ro[d][p] = res[32] ? res[31:0] : 32'd0;
                    m_re[d][p] = !res[32];
                end
            end
            if (win[d] >= 0) begin
                m_iv[d]  = 1'b1;
                m_own[d] = (win[d] == 1);
                m_op[d]  = {r_fn[d][win[d]], r_imm[d][win[d]], r_in1[d][win[d]], r_in2[d][win[d]]};
                m_last[d] = win[d];
            end else begin
                m_iv[d] = 1'b0;
            end
            if (win[d] == 1) m_cnt[d] = 0;
            else if (r_val[d][1] && m_cnt[d] < smax[d]) m_cnt[d]++;
            last_win[d] = win[d];
        end
        if (!rst) model_reset();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if ({i_val[d], i_fn[d], i_imm[d], i_in1[d], i_in2[d]} !== 77'd0) begin
                n_fail++;
                $display("FAIL reset_issue d%0d: got v=%b in1=%h want all zero", d, i_val[d], i_in1[d]);
            end
            for (int p = 0; p < 2; p++) begin
                n_tests++;
                if ({s_val[d][p], s_err[d][p], s_out[d][p]} !== 34'd0) begin
                    n_fail++;
                    $display("FAIL reset_rsp d%0d p%0d: got v=%b e=%b o=%h want zero", d, p,
                             s_val[d][p], s_err[d][p], s_out[d][p]);
                end
            end
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_port0_op();
        r_val[0][0] = 1'b1; r_fn[0][0] = 5'b00001; r_imm[0][0] = 7'h00;
        r_in1[0][0] = 32'h0123_4567; r_in2[0][0] = 32'h89AB_CDEF;
        tick();
        r_val[0][0] = 1'b0;
        n_tests++;
        if (i_val[0] !== 1'b1 || i_in1[0] !== 32'h0123_4567 || s_val[0][0] !== 1'b0) begin
            n_fail++;
            $display("FAIL p0_issue: got ise_val=%b in1=%h rsp_val=%b want 1 01234567 0", i_val[0], i_in1[0], s_val[0][0]);
        end
        tick();
        n_tests++;
        if (i_val[0] !== 1'b0 || s_val[0][0] !== 1'b1 || s_out[0][0] !== 32'h8ACF_1356 || s_err[0][0] !== 1'b0) begin
            n_fail++;
            $display("FAIL p0_rsp: got ise_val=%b v=%b o=%h e=%b want 0 1 8acf1356 0",
                     i_val[0], s_val[0][0], s_out[0][0], s_err[0][0]);
        end
        tick();
    endtask

    task automatic test_port1_err();
        r_val[0][1] = 1'b1; r_fn[0][1] = 5'b00011; r_imm[0][1] = 7'h00;
        r_in1[0][1] = 32'hCAFE_0001; r_in2[0][1] = 32'h0000_0042;
        s_rdy[0][1] = 1'b0;
        tick();
        r_val[0][1] = 1'b0;
        tick();
        repeat (2) begin
            n_tests++;
            if (s_val[0][1] !== 1'b1 || s_err[0][1] !== 1'b1 || s_out[0][1] !== 32'd0) begin
                n_fail++;
                $display("FAIL p1_err: got v=%b e=%b o=%h want 1 1 00000000", s_val[0][1], s_err[0][1], s_out[0][1]);
            end
            tick();
        end
        s_rdy[0][1] = 1'b1;
        tick();
    endtask

    task automatic test_rr_alternate();
        for (int i = 0; i < 6; i++) begin
            for (int p = 0; p < 2; p++) begin
                r_val[0][p] = 1'b1; r_fn[0][p] = 5'($urandom_range(0, 2));
                r_imm[0][p] = 7'($urandom); r_in1[0][p] = $urandom; r_in2[0][p] = $urandom;
            end
            tick();
            n_tests++;
            if (last_win[0] != (i % 2) || i_val[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_alt cycle %0d: got grant=%0d ise_val=%b want %0d 1", i, last_win[0], i_val[0], i % 2);
            end
        end
        idle_inputs();
        repeat (3) tick();
    endtask

    task automatic test_starve();
        int tries;
        r_val[1][1] = 1'b1; r_fn[1][1] = 5'd2; r_imm[1][1] = 7'd3;
        r_in1[1][1] = $urandom; r_in2[1][1] = $urandom;
        s_rdy[1][1] = 1'b0;
        tick();
        r_val[1][0] = 1'b1; r_fn[1][0] = 5'd0; r_in1[1][0] = $urandom; r_in2[1][0] = $urandom;
        repeat (6) begin
            tick();
            n_tests++;
            if (q_rdy[1][1] !== 1'b0) begin
                n_fail++;
                $display("FAIL starve_block: got req1_rdy=%b want 0 while rsp1 held", q_rdy[1][1]);
            end
        end
        tries = 0;
        while (m_iv[1] && !m_own[1] && tries < 4) begin
            tick();
            tries++;
        end
        s_rdy[1][1] = 1'b1;
        tick();
        n_tests++;
        if (last_win[1] != 1) begin
            n_fail++;
            $display("FAIL starve_force: got grant=%0d want 1", last_win[1]);
        end
        repeat (8) tick();
        idle_inputs();
        repeat (3) tick();
    endtask

    task automatic test_rsp_stall();
        logic [32:0] res;
        r_val[0][0] = 1'b1; r_fn[0][0] = 5'd2; r_imm[0][0] = 7'd4;
        r_in1[0][0] = 32'h1000_0000; r_in2[0][0] = 32'h0000_0F00;
        res = ise_ref(5'd2, 7'd4, 32'h1000_0000, 32'h0000_0F00);
        s_rdy[0][0] = 1'b0;
        tick();
        r_in1[0][0] = 32'h5555_AAAA;
        r_val[0][1] = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            r_fn[0][1] = 5'($urandom_range(0, 3)); r_imm[0][1] = 7'($urandom);
            r_in1[0][1] = $urandom; r_in2[0][1] = $urandom;
            tick();
            n_tests++;
            if (q_rdy[0][0] !== 1'b0 || s_val[0][0] !== 1'b1 || s_out[0][0] !== res[31:0]) begin
                n_fail++;
                $display("FAIL stall cycle %0d: got rdy0=%b v=%b o=%h want 0 1 %h", i,
                         q_rdy[0][0], s_val[0][0], s_out[0][0], res[31:0]);
            end
        end
        s_rdy[0][0] = 1'b1;
        repeat (3) tick();
        idle_inputs();
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        r_val[0][0] = 1'b1; r_fn[0][0] = 5'd1; r_in1[0][0] = 32'd7; r_in2[0][0] = 32'd9;
        r_val[1][1] = 1'b1; r_fn[1][1] = 5'd0; r_in1[1][1] = 32'd3; r_in2[1][1] = 32'd5;
        tick();
        idle_inputs();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            for (int d = 0; d < 2; d++) begin
                n_tests++;
                if (i_val[d] !== 1'b0 || s_val[d][0] !== 1'b0 || s_val[d][1] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_mid d%0d cycle %0d: got ise_val=%b rsp_val=%b%b want 0 00",
                             d, i, i_val[d], s_val[d][1], s_val[d][0]);
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            for (int d = 0; d < 2; d++)
                for (int p = 0; p < 2; p++) begin
                    r_val[d][p] = ($urandom_range(0, 9) < 6);
                    s_rdy[d][p] = ($urandom_range(0, 9) < 7);
                    r_fn[d][p]  = 5'($urandom); r_imm[d][p] = 7'($urandom);
                    r_in1[d][p] = $urandom;     r_in2[d][p] = $urandom;
                end
            tick();
        end
        idle_inputs();
        repeat (4) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_port0_op();
        test_port1_err();
        test_rr_alternate();
        test_starve();
        test_rsp_stall();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
